// File: rtl/mux4_sched_pkg.sv
// Shared types, widths and helpers for the mux4_rr_sched round-robin scheduler.
package mux4_sched_pkg;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned SEL_W   = 2;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    // Pointer to the requester after k, wrapping 3 -> 0.
    function automatic logic [SEL_W-1:0] next_ptr(input logic [SEL_W-1:0] k);
        return k + SEL_W'(1);
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: first set req bit at or after ptr, wrapping.
module rr_pick4
    import mux4_sched_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    output logic               any,
    output logic [SEL_W-1:0]   winner
);

    logic             found;
    logic [SEL_W-1:0] idx;

    always_comb begin
        any    = |req;
        winner = ptr;
        found  = 1'b0;
        idx    = ptr;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = ptr + SEL_W'(i);
            if (!found && req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux4_rr_sched.sv
// Round-robin scheduler driving the 4:1 select and a registered valid/ready output.
// Optional requester lock is enabled by defining MUX4_SCHED_LOCK_EN.
module mux4_rr_sched
    import mux4_sched_pkg::*;
#(
    parameter int unsigned DATA_W    = 1,
    parameter int unsigned RESET_PTR = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic [DATA_W-1:0]  w0,
    input  logic [DATA_W-1:0]  w1,
    input  logic [DATA_W-1:0]  w2,
    input  logic [DATA_W-1:0]  w3,
`ifdef MUX4_SCHED_LOCK_EN
    input  logic               lock,
`endif
    output logic [NUM_REQ-1:0] gnt,
    output logic [SEL_W-1:0]   S,
    output logic               f_valid,
    input  logic               f_ready,
    output logic [DATA_W-1:0]  f
);

    localparam logic [SEL_W-1:0] RST_PTR = SEL_W'(RESET_PTR);

    state_e              state_q;
    logic [SEL_W-1:0]    ptr_q;
    logic [SEL_W-1:0]    sel_q;
    logic [DATA_W-1:0]   f_q;
    logic [NUM_REQ-1:0]  gnt_q;

    logic                any_c;
    logic [SEL_W-1:0]    rr_win_c;
    logic [SEL_W-1:0]    win_d;
    logic [DATA_W-1:0]   word_d;
    logic                take_c;

    rr_pick4 u_pick (
        .req    (req),
        .ptr    (ptr_q),
        .any    (any_c),
        .winner (rr_win_c)
    );

`ifdef MUX4_SCHED_LOCK_EN
    logic lock_q;

    // A locked requester keeps priority only while lock stays high and it still requests.
    always_comb begin
        win_d = rr_win_c;
        if (lock_q && lock && req[sel_q]) begin
            win_d = sel_q;
        end
    end
`else
    assign win_d = rr_win_c;
`endif

    always_comb begin
        word_d = w0;
        case (win_d)
            2'd0:    word_d = w0;
            2'd1:    word_d = w1;
            2'd2:    word_d = w2;
            default: word_d = w3;
        endcase
    end

    assign take_c = any_c && ((state_q == IDLE) || f_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= RST_PTR;
            sel_q   <= RST_PTR;
            f_q     <= '0;
            gnt_q   <= '0;
`ifdef MUX4_SCHED_LOCK_EN
            lock_q  <= 1'b0;
`endif
        end else begin
            gnt_q <= '0;
            if (take_c) begin
                state_q <= HOLD;
                ptr_q   <= next_ptr(win_d);
                sel_q   <= win_d;
                f_q     <= word_d;
                gnt_q   <= NUM_REQ'(1) << win_d;
`ifdef MUX4_SCHED_LOCK_EN
                lock_q  <= lock;
`endif
            end else if (state_q == HOLD && f_ready) begin
                // Drained with nothing pending: S and f keep their last values.
                state_q <= IDLE;
            end
        end
    end

    assign gnt     = gnt_q;
    assign S       = sel_q;
    assign f       = f_q;
    assign f_valid = (state_q == HOLD);

endmodule

// File: tb/tb_mux4_rr_sched.sv
// Directed scoreboard bench for mux4_rr_sched (lock steps only when MUX4_SCHED_LOCK_EN is defined).
module tb_mux4_rr_sched;

    localparam int unsigned DW = 4;

    typedef struct packed {
        logic [3:0]    gnt;
        logic [1:0]    s;
        logic [DW-1:0] f;
        logic          fv;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [3:0]    req = 4'b0000;
    logic [DW-1:0] w0 = 4'hA;
    logic [DW-1:0] w1 = 4'hB;
    logic [DW-1:0] w2 = 4'hC;
    logic [DW-1:0] w3 = 4'hD;
    logic          lock = 1'b0;
    logic          f_ready = 1'b0;
    logic [3:0]    gnt;
    logic [1:0]    S;
    logic          f_valid;
    logic [DW-1:0] f;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    mux4_rr_sched #(.DATA_W(DW), .RESET_PTR(0)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .w0      (w0),
        .w1      (w1),
        .w2      (w2),
        .w3      (w3),
`ifdef MUX4_SCHED_LOCK_EN
        .lock    (lock),
`endif
        .gnt     (gnt),
        .S       (S),
        .f_valid (f_valid),
        .f_ready (f_ready),
        .f       (f)
    );

    always #5 clk = ~clk;

    // Drive one cycle of stimulus, queue the expected post-edge outputs, then pop and compare.
    task automatic step(input logic r, input logic [3:0] rq, input logic rdy,
                        input logic [3:0] eg, input logic [1:0] es,
                        input logic [DW-1:0] ef, input logic efv, input string tag);
        exp_t e;
        rst     = r;
        req     = rq;
        f_ready = rdy;
        exp_q.push_back('{gnt: eg, s: es, f: ef, fv: efv});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        checks++;
        assert (gnt === e.gnt) else begin
            errors++;
            $error("FAIL %s gnt observed %b expected %b", tag, gnt, e.gnt);
        end
        checks++;
        assert (S === e.s) else begin
            errors++;
            $error("FAIL %s S observed %0d expected %0d", tag, S, e.s);
        end
        checks++;
        assert (f_valid === e.fv) else begin
            errors++;
            $error("FAIL %s f_valid observed %b expected %b", tag, f_valid, e.fv);
        end
        if (e.fv) begin
            checks++;
            assert (f === e.f) else begin
                errors++;
                $error("FAIL %s f observed %h expected %h", tag, f, e.f);
            end
        end
    endtask

    initial begin
        // Reset and idle
        step(1, 4'b0000, 0, 4'b0000, 2'd0, '0, 0, "rst0");
        step(1, 4'b0000, 0, 4'b0000, 2'd0, '0, 0, "rst1");
        for (int i = 0; i < 5; i++)
            step(0, 4'b0000, 0, 4'b0000, 2'd0, '0, 0, "idle");
        checks++;
        assert (f === '0) else begin
            errors++;
            $error("FAIL rst_f observed %h expected 0", f);
        end

        // Single request from 2, then drain
        w2 = 4'h1;
        step(0, 4'b0100, 1, 4'b0100, 2'd2, 4'h1, 1, "single_cap");
        step(0, 4'b0000, 1, 4'b0000, 2'd2, 4'h1, 0, "single_drain");
        checks++;
        assert (f === 4'h1) else begin
            errors++;
            $error("FAIL drain_f_hold observed %h expected 1", f);
        end
        w2 = 4'hC;

        // All requesting, pointer at 3 after the previous grant
        step(0, 4'b1111, 1, 4'b1000, 2'd3, 4'hD, 1, "rr3");
        step(0, 4'b1111, 1, 4'b0001, 2'd0, 4'hA, 1, "rr0");
        step(0, 4'b1111, 1, 4'b0010, 2'd1, 4'hB, 1, "rr1");
        step(0, 4'b1111, 1, 4'b0100, 2'd2, 4'hC, 1, "rr2");
        step(0, 4'b1111, 1, 4'b1000, 2'd3, 4'hD, 1, "rr3b");
        step(0, 4'b1111, 1, 4'b0001, 2'd0, 4'hA, 1, "rr0b");

        // Back-pressure: capture 1, stall with req=1000, then release
        step(0, 4'b0010, 1, 4'b0010, 2'd1, 4'hB, 1, "bp_cap1");
        for (int i = 0; i < 4; i++)
            step(0, 4'b1000, 0, 4'b0000, 2'd1, 4'hB, 1, "bp_stall");
        step(0, 4'b1000, 1, 4'b1000, 2'd3, 4'hD, 1, "bp_cap3");

        // Reset while holding a word
        step(1, 4'b0000, 0, 4'b0000, 2'd0, '0, 0, "mid_rst");
        checks++;
        assert (f === '0) else begin
            errors++;
            $error("FAIL mid_rst_f observed %h expected 0", f);
        end
        step(0, 4'b0011, 1, 4'b0001, 2'd0, 4'hA, 1, "post_rst0");
        step(0, 4'b0010, 1, 4'b0010, 2'd1, 4'hB, 1, "post_rst1");
        step(0, 4'b0000, 0, 4'b0000, 2'd1, 4'hB, 1, "hold_noreq");
        step(0, 4'b0000, 1, 4'b0000, 2'd1, 4'hB, 0, "drain2");
        step(0, 4'b0000, 1, 4'b0000, 2'd1, 4'hB, 0, "idle_ready");

`ifdef MUX4_SCHED_LOCK_EN
        step(1, 4'b0000, 0, 4'b0000, 2'd0, '0, 0, "lk_rst");
        lock = 1'b1;
        step(0, 4'b0100, 1, 4'b0100, 2'd2, 4'hC, 1, "lk_cap2");
        step(0, 4'b1110, 1, 4'b0100, 2'd2, 4'hC, 1, "lk_again2");
        lock = 1'b0;
        step(0, 4'b1110, 1, 4'b1000, 2'd3, 4'hD, 1, "lk_rel3");
        step(0, 4'b1110, 1, 4'b0010, 2'd1, 4'hB, 1, "lk_rel1");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
